// File: rtl/forth_mem_pkg.sv
// Shared types and constants for the Forth CPU memory responder.
package forth_mem_pkg;

  localparam int FM_WIDTH      = 16;
  localparam int FM_DEPTH_LOG2 = 10;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fm_state_e;

  // Counter preload for a given wait-state count; zero wait states never enter WAIT.
  function automatic logic [CNT_W-1:0] wait_load(input int ws);
    if (ws > 0) begin
      wait_load = CNT_W'(ws - 1);
    end else begin
      wait_load = {CNT_W{1'b0}};
    end
  endfunction

endpackage

// File: rtl/forth_mem_array.sv
// Single-port synchronous RAM: write-enable plus registered (read-first) read.
module forth_mem_array
  import forth_mem_pkg::*;
#(
  parameter int WIDTH      = FM_WIDTH,
  parameter int DEPTH_LOG2 = FM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_r [2**DEPTH_LOG2];

  // Storage write and registered read of the same port address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    rdata <= mem_r[addr];
  end

endmodule

// File: rtl/forth_mem_responder.sv
// Memory responder for the Forth CPU bus with configurable wait states.
// Optional out-of-range detection: define FORTH_MEM_RANGE_CHECK_EN.
module forth_mem_responder
  import forth_mem_pkg::*;
#(
  parameter int WIDTH       = FM_WIDTH,
  parameter int DEPTH_LOG2  = FM_DEPTH_LOG2,
  parameter int WAIT_STATES = 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             mem_valid,
  input  logic             mem_nwr,
  input  logic [WIDTH-1:0] mem_address,
  input  logic [WIDTH-1:0] mem_data_in,
  output logic [WIDTH-1:0] mem_data_out,
  output logic             mem_ready,
  output logic             mem_error
);

`ifdef FORTH_MEM_RANGE_CHECK_EN
  localparam bit RANGE_CHECK_EN = 1'b1;
`else
  localparam bit RANGE_CHECK_EN = 1'b0;
`endif

  fm_state_e             state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [DEPTH_LOG2-1:0] addr_r;
  logic [WIDTH-1:0]      wdata_r;
  logic [WIDTH-1:0]      hold_r;
  logic                  nwr_r;
  logic                  err_lat_r;
  logic                  ready_r;
  logic                  error_r;
  logic                  range_err_s;
  logic                  ram_we_s;
  logic [DEPTH_LOG2-1:0] ram_addr_s;
  logic [WIDTH-1:0]      ram_rdata_s;

  // Out-of-range flag for the address currently on the bus.
  always_comb begin
    range_err_s = RANGE_CHECK_EN && ((mem_address >> DEPTH_LOG2) != {WIDTH{1'b0}});
  end

  // RAM is addressed from the bus while idle so zero-wait reads have data in RESP.
  always_comb begin
    ram_addr_s = addr_r;
    ram_we_s   = 1'b0;
    if (state_r == ST_IDLE) begin
      ram_addr_s = mem_address[DEPTH_LOG2-1:0];
    end else begin
      ram_addr_s = addr_r;
    end
    if ((state_r == ST_RESP) && !nwr_r && !err_lat_r && nreset) begin
      ram_we_s = 1'b1;
    end else begin
      ram_we_s = 1'b0;
    end
  end

  forth_mem_array #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (wdata_r),
    .rdata (ram_rdata_s)
  );

  // Transfer FSM with latched request and registered strobes.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      addr_r    <= {DEPTH_LOG2{1'b0}};
      wdata_r   <= {WIDTH{1'b0}};
      hold_r    <= {WIDTH{1'b0}};
      nwr_r     <= 1'b1;
      err_lat_r <= 1'b0;
      ready_r   <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      ready_r <= 1'b0;
      error_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (mem_valid) begin
            addr_r    <= mem_address[DEPTH_LOG2-1:0];
            wdata_r   <= mem_data_in;
            nwr_r     <= mem_nwr;
            err_lat_r <= range_err_s;
            cnt_r     <= wait_load(WAIT_STATES);
            if (WAIT_STATES > 0) begin
              state_r <= ST_WAIT;
            end else begin
              state_r <= ST_RESP;
              ready_r <= 1'b1;
              error_r <= range_err_s;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= ST_RESP;
            ready_r <= 1'b1;
            error_r <= err_lat_r;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
          if (nwr_r) begin
            hold_r <= err_lat_r ? {WIDTH{1'b0}} : ram_rdata_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Read data is live in RESP and held afterwards until the next read response.
  always_comb begin
    mem_data_out = hold_r;
    if ((state_r == ST_RESP) && nwr_r) begin
      mem_data_out = err_lat_r ? {WIDTH{1'b0}} : ram_rdata_s;
    end else begin
      mem_data_out = hold_r;
    end
  end

  assign mem_ready = ready_r;
  assign mem_error = error_r;

endmodule

// File: tb/tb_forth_mem_responder.sv
// Scoreboard bench for forth_mem_responder: unit 0 has one wait state, unit 1 none.
module tb_forth_mem_responder;

`ifdef FORTH_MEM_RANGE_CHECK_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  typedef struct {
    logic        nwr;
    logic [15:0] data;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        nreset_v [2];
  logic        valid_v   [2];
  logic        nwr_v     [2];
  logic [15:0] addr_v    [2];
  logic [15:0] wdata_v   [2];
  logic [15:0] dout_v    [2];
  logic        ready_v   [2];
  logic        err_v     [2];

  int          total = 0;
  int          bad   = 0;
  exp_t        sb_q[$];
  logic [15:0] model_mem [2][1024];
  logic [15:0] last_rd   [2];

  always #5 clk = ~clk;

  forth_mem_responder #(.WAIT_STATES(1)) u_ws1 (
    .clk(clk), .nreset(nreset_v[0]), .mem_valid(valid_v[0]), .mem_nwr(nwr_v[0]),
    .mem_address(addr_v[0]), .mem_data_in(wdata_v[0]), .mem_data_out(dout_v[0]),
    .mem_ready(ready_v[0]), .mem_error(err_v[0])
  );

  forth_mem_responder #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .nreset(nreset_v[1]), .mem_valid(valid_v[1]), .mem_nwr(nwr_v[1]),
    .mem_address(addr_v[1]), .mem_data_in(wdata_v[1]), .mem_data_out(dout_v[1]),
    .mem_ready(ready_v[1]), .mem_error(err_v[1])
  );

  function automatic logic exp_err(input logic [15:0] a);
    return RC_EN && (a[15:10] != 6'd0);
  endfunction

  // One request: push expectation, drive, wait for ready, pop and compare.
  task automatic do_req(input int u, input logic nwr, input logic [15:0] addr,
                        input logic [15:0] wdata, input int lat, input bit drop,
                        input bit scramble);
    exp_t e;
    int   n;
    bit   seen;
    e.nwr = nwr;
    e.err = exp_err(addr);
    e.lat = lat;
    if (nwr) e.data = e.err ? 16'h0000 : model_mem[u][addr[9:0]];
    else     e.data = last_rd[u];
    sb_q.push_back(e);
    if (nwr) last_rd[u] = e.data;
    else if (!e.err) model_mem[u][addr[9:0]] = wdata;
    valid_v[u] = 1'b1;
    nwr_v[u]   = nwr;
    addr_v[u]  = addr;
    wdata_v[u] = wdata;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (ready_v[u] === 1'b1) seen = 1'b1;
      else if (scramble) begin
        addr_v[u]  = 16'($urandom);
        wdata_v[u] = 16'($urandom);
      end
    end
    e = sb_q.pop_front();
    total++;
    if (!seen || n !== e.lat) begin
      bad++;
      $display("FAIL latency u%0d addr=%h got=%0d (seen=%0b) want=%0d", u, addr, n, seen, e.lat);
    end
    total++;
    if (dout_v[u] !== e.data) begin
      bad++;
      $display("FAIL data u%0d addr=%h got=%h want=%h", u, addr, dout_v[u], e.data);
    end
    total++;
    if (err_v[u] !== e.err) begin
      bad++;
      $display("FAIL error u%0d addr=%h got=%b want=%b", u, addr, err_v[u], e.err);
    end
    if (drop) valid_v[u] = 1'b0;
  endtask

  task automatic idle(input int u);
    @(negedge clk);
    total++;
    if (ready_v[u] !== 1'b0 || err_v[u] !== 1'b0) begin
      bad++;
      $display("FAIL idle_strobe u%0d got ready=%b err=%b want 0 0", u, ready_v[u], err_v[u]);
    end
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      nreset_v[u] = 1'b0; valid_v[u] = 1'b0; nwr_v[u] = 1'b1;
      addr_v[u] = 16'h0000; wdata_v[u] = 16'h0000; last_rd[u] = 16'h0000;
    end
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      total++;
      if (ready_v[u] !== 1'b0) begin bad++; $display("FAIL reset_ready u%0d got=%b want=0", u, ready_v[u]); end
      total++;
      if (err_v[u] !== 1'b0) begin bad++; $display("FAIL reset_error u%0d got=%b want=0", u, err_v[u]); end
      total++;
      if (dout_v[u] !== 16'h0000) begin bad++; $display("FAIL reset_data u%0d got=%h want=0000", u, dout_v[u]); end
      nreset_v[u] = 1'b1;
    end
  endtask

  task automatic test_write_read();
    do_req(0, 1'b0, 16'h0010, 16'h1234, 2, 1'b1, 1'b0);
    idle(0);
    do_req(0, 1'b1, 16'h0010, 16'h0000, 2, 1'b1, 1'b0);
    total++;
    if (dout_v[0] !== 16'h1234) begin bad++; $display("FAIL read_0010 got=%h want=1234", dout_v[0]); end
    idle(0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      do_req(1, 1'b0, 16'(i), 16'h1000 + 16'(i * 16'h0111), 1, 1'b1, 1'b0);
      idle(1);
    end
    for (int i = 0; i < 4; i++) begin
      do_req(1, 1'b1, 16'(i), 16'h0000, (i == 0) ? 1 : 2, (i == 3), 1'b0);
    end
    idle(1);
  endtask

  task automatic test_reset_abort();
    do_req(0, 1'b0, 16'h0020, 16'h1111, 2, 1'b1, 1'b0);
    idle(0);
    valid_v[0] = 1'b1; nwr_v[0] = 1'b0; addr_v[0] = 16'h0020; wdata_v[0] = 16'hBEEF;
    idle(0);
    nreset_v[0] = 1'b0;
    valid_v[0]  = 1'b0;
    idle(0);
    total++;
    if (dout_v[0] !== 16'h0000) begin bad++; $display("FAIL abort_data got=%h want=0000", dout_v[0]); end
    last_rd[0]  = 16'h0000;
    nreset_v[0] = 1'b1;
    repeat (2) idle(0);
    do_req(0, 1'b1, 16'h0020, 16'h0000, 2, 1'b1, 1'b0);
    total++;
    if (dout_v[0] !== 16'h1111) begin bad++; $display("FAIL abort_old_value got=%h want=1111", dout_v[0]); end
    idle(0);
  endtask

  task automatic test_latch_hold();
    do_req(0, 1'b0, 16'h0033, 16'hC0DE, 2, 1'b1, 1'b1);
    idle(0);
    do_req(0, 1'b1, 16'h0033, 16'h0000, 2, 1'b1, 1'b1);
    total++;
    if (dout_v[0] !== 16'hC0DE) begin bad++; $display("FAIL latched_read got=%h want=c0de", dout_v[0]); end
    idle(0);
  endtask

  task automatic test_range();
`ifdef FORTH_MEM_RANGE_CHECK_EN
    do_req(0, 1'b0, 16'h0000, 16'h5A5A, 2, 1'b1, 1'b0); idle(0);
    do_req(0, 1'b0, 16'h0400, 16'h7777, 2, 1'b1, 1'b0);
    total++;
    if (err_v[0] !== 1'b1) begin bad++; $display("FAIL range_write_err got=%b want=1", err_v[0]); end
    idle(0);
    do_req(0, 1'b1, 16'h0000, 16'h0000, 2, 1'b1, 1'b0);
    total++;
    if (dout_v[0] !== 16'h5A5A) begin bad++; $display("FAIL range_no_wrap got=%h want=5a5a", dout_v[0]); end
    idle(0);
    do_req(0, 1'b1, 16'h0400, 16'h0000, 2, 1'b1, 1'b0); idle(0);
`else
    do_req(0, 1'b0, 16'h0405, 16'hA5A5, 2, 1'b1, 1'b0); idle(0);
    do_req(0, 1'b1, 16'h0005, 16'h0000, 2, 1'b1, 1'b0);
    total++;
    if (dout_v[0] !== 16'hA5A5 || err_v[0] !== 1'b0) begin
      bad++; $display("FAIL wrap_read got=%h err=%b want=a5a5 err=0", dout_v[0], err_v[0]);
    end
    idle(0);
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_abort();
    test_latch_hold();
    test_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/forth_mem_responder.md
FORTH_MEM_RESPONDER -- requirements
Module: forth_mem_responder

Interface
REQ-001 Parameter WIDTH, default 16, data and address width in bits.
REQ-002 Parameter DEPTH_LOG2, default 10, log2 of memory depth in words.
REQ-003 Parameter WAIT_STATES, default 1, extra cycles inserted before each response (0..15).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 nreset  input  1  synchronous, active-low reset.
REQ-006 mem_valid  input  1  CPU request strobe; held high until mem_ready.
REQ-007 mem_nwr  input  1  1 = read, 0 = write.
REQ-008 mem_address  input  WIDTH  word address from CPU.
REQ-009 mem_data_in  input  WIDTH  write data from CPU.
REQ-010 mem_data_out  output  WIDTH  read data to CPU.
REQ-011 mem_ready  output  1  one-cycle response strobe.
REQ-012 mem_error  output  1  one-cycle error strobe, coincident with mem_ready.

Function
REQ-013 FSM states: IDLE, WAIT, RESP.
REQ-014 IDLE: on mem_valid=1, latch address, data and nwr; go to WAIT if WAIT_STATES>0, else RESP.
REQ-015 WAIT: down-counter loaded with WAIT_STATES-1 at acceptance; go to RESP when it reaches 0.
REQ-016 Latency: mem_ready is asserted exactly WAIT_STATES+1 cycles after the acceptance edge.
REQ-017 RESP: mem_ready=1 for exactly one cycle, then unconditionally return to IDLE.
REQ-018 Reads: mem_data_out is valid in the RESP cycle and holds its value until the next read response.
REQ-019 Writes: the array is updated at the end of the RESP cycle only; mem_data_out is unchanged.
REQ-020 Inputs changing after acceptance are ignored; the latched copies are used.
REQ-021 mem_valid still high in the IDLE cycle after RESP is a new request (back-to-back throughput: one request per WAIT_STATES+2 cycles).
REQ-022 mem_valid low in IDLE: no state change, mem_ready=0, mem_error=0.
REQ-023 Address decode: array index = mem_address[DEPTH_LOG2-1:0].

Reset
REQ-024 nreset=0 forces IDLE, counter 0, mem_ready=0, mem_error=0, mem_data_out=0 on the next edge.
REQ-025 Reset during WAIT or RESP aborts the transfer; no write is committed and no mem_ready is emitted.
REQ-026 Array contents are not cleared by reset.

Configuration
REQ-027 Macro FORTH_MEM_RANGE_CHECK_EN enables out-of-range detection.
REQ-028 With the macro: an address with any bit above DEPTH_LOG2-1 set yields mem_error=1 with mem_ready in RESP; writes are suppressed and reads return 0.
REQ-029 Without the macro: mem_error is tied 0; upper address bits are ignored (address wraps modulo 2^DEPTH_LOG2).

Structure
REQ-030 Package forth_mem_pkg holds the FSM state encoding, the default WIDTH/DEPTH_LOG2 constants and the wait-counter width (4).
REQ-031 Storage is one sub-module, forth_mem_array: single-port synchronous RAM, WIDTH x 2^DEPTH_LOG2, write-enable plus registered read.

Verification
REQ-032 WAIT_STATES=1: write 0x1234 to 0x0010, then read 0x0010 -> each mem_ready 2 cycles after acceptance; read returns 0x1234.
REQ-033 WAIT_STATES=0: mem_valid held high for 4 reads of 0x0000..0x0003 -> mem_ready every 2nd cycle, data matches preloaded values.
REQ-034 Reset pulsed in WAIT during a write of 0xBEEF to 0x0020 -> no mem_ready; a later read of 0x0020 returns the old value.
REQ-035 With FORTH_MEM_RANGE_CHECK_EN, DEPTH_LOG2=10: write to 0x0400 -> mem_error=1 with mem_ready; read of 0x0000 unchanged.
REQ-036 Without the macro: write 0xA5A5 to 0x0405, read 0x0005 -> 0xA5A5, mem_error=0.
REQ-037 mem_address and mem_data_in toggled during WAIT -> the response uses the values latched at acceptance.
